// File: rtl/spinner_show_sequencer.sv
// Playlist sequencer for the seven-segment spinner: steps through programmed spinner configs,
// holding each for (dwell+1) revolutions. Define SEQ_SHUFFLE_EN for LFSR-shuffled entry order.
module spinner_show_sequencer #(
    parameter int STEPS       = 8,
    parameter int DWELL_WIDTH = 4,
    parameter int REV_STEPS   = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr_en,
    input  logic [$clog2(STEPS)-1:0] wr_addr,
    input  logic [DWELL_WIDTH+5:0]   wr_data,
    input  logic [$clog2(STEPS)-1:0] last_addr,
    input  logic                     run,
    input  logic                     pos_tick,
    output logic [2:0]               cfg_speed,
    output logic                     cfg_tail,
    output logic                     cfg_direction,
    output logic                     cfg_invert,
    output logic [$clog2(STEPS)-1:0] step_idx,
    output logic                     step_done,
    output logic                     busy
);

    localparam int AW    = $clog2(STEPS);
    localparam int REV_W = (REV_STEPS > 1) ? $clog2(REV_STEPS) : 1;

    typedef struct packed {
        logic [DWELL_WIDTH-1:0] dwell;
        logic                   invert;
        logic                   direction;
        logic                   tail;
        logic [2:0]             speed;
    } entry_t;

    typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

    state_t                 state_q, state_d;
    entry_t                 playlist [STEPS];
    entry_t                 cur_entry;
    logic [REV_W-1:0]       rev_cnt;
    logic [DWELL_WIDTH-1:0] dwell_cnt;
    logic [AW-1:0]          next_idx;
    logic                   rev_last;
    logic                   do_load, do_tick, do_finish, do_stop;

    // Array read is the registered contents, so a same-cycle write lands after LOAD samples it
    assign cur_entry = playlist[step_idx];
    assign rev_last  = (rev_cnt == REV_W'(REV_STEPS - 1));

`ifdef SEQ_SHUFFLE_EN
    logic [7:0] lfsr;
    logic       lfsr_fb;

    assign lfsr_fb  = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];
    assign next_idx = (lfsr[AW-1:0] <= last_addr) ? lfsr[AW-1:0] : '0;
`else
    // ">=" also wraps cleanly when last_addr is lowered below the current index
    assign next_idx = (step_idx >= last_addr) ? '0 : step_idx + AW'(1);
`endif

    always_comb begin
        state_d   = state_q;
        do_load   = 1'b0;
        do_tick   = 1'b0;
        do_finish = 1'b0;
        do_stop   = 1'b0;
        case (state_q)
            IDLE: begin
                if (run) state_d = LOAD;
            end
            LOAD: begin
                if (!run) begin
                    state_d = IDLE;
                    do_stop = 1'b1;
                end else begin
                    state_d = RUN;
                    do_load = 1'b1;
                end
            end
            RUN: begin
                // Dropping run wins over a terminating tick in the same cycle
                if (!run) begin
                    state_d = IDLE;
                    do_stop = 1'b1;
                end else if (pos_tick) begin
                    do_tick = 1'b1;
                    if (rev_last && dwell_cnt == '0) begin
                        do_finish = 1'b1;
                        state_d   = LOAD;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            busy          <= 1'b0;
            step_done     <= 1'b0;
            step_idx      <= '0;
            cfg_speed     <= '0;
            cfg_tail      <= 1'b0;
            cfg_direction <= 1'b0;
            cfg_invert    <= 1'b0;
            rev_cnt       <= '0;
            dwell_cnt     <= '0;
            for (int i = 0; i < STEPS; i++) playlist[i] <= '0;
`ifdef SEQ_SHUFFLE_EN
            lfsr          <= 8'h01;
`endif
        end else begin
            state_q   <= state_d;
            busy      <= (state_d != IDLE);
            step_done <= do_finish;

            if (wr_en) playlist[wr_addr] <= entry_t'(wr_data);

            if (do_load) begin
                cfg_speed     <= cur_entry.speed;
                cfg_tail      <= cur_entry.tail;
                cfg_direction <= cur_entry.direction;
                cfg_invert    <= cur_entry.invert;
                dwell_cnt     <= cur_entry.dwell;
                rev_cnt       <= '0;
            end

            if (do_stop) begin
                rev_cnt   <= '0;
                dwell_cnt <= '0;
            end

            if (do_tick) begin
                if (rev_last) begin
                    rev_cnt <= '0;
                    if (dwell_cnt != '0) dwell_cnt <= dwell_cnt - DWELL_WIDTH'(1);
                end else begin
                    rev_cnt <= rev_cnt + REV_W'(1);
                end
            end

            if (do_finish) begin
                step_idx <= next_idx;
`ifdef SEQ_SHUFFLE_EN
                lfsr     <= {lfsr[6:0], lfsr_fb};
`endif
            end
        end
    end

endmodule

// File: tb/tb_spinner_show_sequencer.sv
// Scoreboard bench for spinner_show_sequencer: stimulus queues expected step_done results,
// a monitor pops and checks them whenever the DUT pulses step_done.
module tb_spinner_show_sequencer;

    logic       clk = 1'b0;
    logic       reset, wr_en, run, pos_tick;
    logic [2:0] wr_addr, last_addr;
    logic [9:0] wr_data;
    logic [2:0] cfg_speed, step_idx;
    logic       cfg_tail, cfg_direction, cfg_invert, step_done, busy;

    spinner_show_sequencer dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .last_addr(last_addr), .run(run), .pos_tick(pos_tick),
        .cfg_speed(cfg_speed), .cfg_tail(cfg_tail), .cfg_direction(cfg_direction),
        .cfg_invert(cfg_invert), .step_idx(step_idx), .step_done(step_done), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         ticks;
        logic [2:0] idx;
        logic [9:0] ent;
    } exp_t;

    exp_t       sbq [$];
    int         total = 0;
    int         bad = 0;
    int         tick_cnt = 0;
    logic [9:0] pl [8];
    logic [7:0] m_lfsr = 8'h01;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h (t=%0t)", name, got, want, $time);
        end
    endtask

    function automatic logic [9:0] ent(input logic [3:0] dwell, input logic inv,
                                       input logic dir, input logic tail, input logic [2:0] spd);
        return {dwell, inv, dir, tail, spd};
    endfunction

    task automatic wr(input logic [2:0] a, input logic [9:0] d);
        @(negedge clk);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        pl[a] = d;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            pos_tick = 1'b1;
            tick_cnt++;
            @(negedge clk);
            pos_tick = 1'b0;
            repeat (2) @(negedge clk);
        end
    endtask

    // Expect the n-th tick from now to end the current entry and move to idx
    task automatic push(input int n, input logic [2:0] idx);
        exp_t e;
        e.ticks = tick_cnt + n;
        e.idx   = idx;
        e.ent   = pl[idx];
        sbq.push_back(e);
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_speed"}, cfg_speed, 0);
        chk({tag, "_tail"}, cfg_tail, 0);
        chk({tag, "_dir"}, cfg_direction, 0);
        chk({tag, "_inv"}, cfg_invert, 0);
        chk({tag, "_idx"}, step_idx, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, step_done, 0);
    endtask

    // Monitor
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (step_done === 1'b1) begin
                if (sbq.size() == 0) begin
                    chk("step_done_unexpected", step_done, 0);
                end else begin
                    e = sbq.pop_front();
                    chk("done_ticks", tick_cnt, e.ticks);
                    chk("done_idx", step_idx, e.idx);
                    @(negedge clk);
                    chk("done_one_cycle", step_done, 0);
                    chk("next_speed", cfg_speed, e.ent[2:0]);
                    chk("next_tail", cfg_tail, e.ent[3]);
                    chk("next_dir", cfg_direction, e.ent[4]);
                    chk("next_inv", cfg_invert, e.ent[5]);
                end
            end
        end
    end

    initial begin
        reset = 1'b1; wr_en = 1'b0; run = 1'b0; pos_tick = 1'b0;
        wr_addr = '0; wr_data = '0; last_addr = '0;
        for (int i = 0; i < 8; i++) pl[i] = '0;
        repeat (3) @(negedge clk);
        chk_reset_state("rst");
        reset = 1'b0;
        repeat (2) @(negedge clk);

`ifdef SEQ_SHUFFLE_EN
        for (int i = 0; i < 8; i++) wr(3'(i), ent(4'd0, 1'b0, 1'b0, 1'b0, 3'(i)));
        last_addr = 3'd7;
        run = 1'b1;
        repeat (2) @(negedge clk);
        chk("shuf_first_idx", step_idx, 0);
        for (int s = 0; s < 16; s++) begin
            logic [2:0] nxt;
            if (s == 10) last_addr = 3'd2;
            nxt = (m_lfsr[2:0] <= last_addr) ? m_lfsr[2:0] : 3'd0;
            m_lfsr = {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
            push(8, nxt);
            ticks(8);
        end
`else
        // Basic stepping, dwell 0 on both entries
        wr(3'd0, ent(4'd0, 1'b0, 1'b0, 1'b1, 3'b101));
        wr(3'd1, ent(4'd0, 1'b0, 1'b1, 1'b0, 3'b010));
        last_addr = 3'd1;
        @(negedge clk);
        run = 1'b1;
        repeat (2) @(negedge clk);
        chk("load_speed", cfg_speed, 3'b101);
        chk("load_tail", cfg_tail, 1);
        chk("load_busy", busy, 1);
        push(8, 3'd1); ticks(8);
        push(8, 3'd0); ticks(8);

        // Entry1 dwell 2: 24 ticks, then wrap to 0
        wr(3'd1, ent(4'd2, 1'b0, 1'b1, 1'b0, 3'b010));
        push(8, 3'd1);  ticks(8);
        push(24, 3'd0); ticks(24);

        // Stop mid-entry; ticks in IDLE ignored; restart reloads full dwell
        ticks(5);
        @(negedge clk);
        run = 1'b0;
        repeat (2) @(negedge clk);
        chk("stop_busy", busy, 0);
        chk("stop_speed_held", cfg_speed, 3'b101);
        chk("stop_idx_held", step_idx, 0);
        ticks(3);
        @(negedge clk);
        run = 1'b1;
        repeat (2) @(negedge clk);
        chk("restart_busy", busy, 1);
        push(8, 3'd1);  ticks(8);
        push(24, 3'd0); ticks(24);

        // Rewrite displayed entry0: no effect until its next LOAD
        wr(3'd0, ent(4'd0, 1'b0, 1'b0, 1'b1, 3'b111));
        repeat (2) @(negedge clk);
        chk("live_write_held", cfg_speed, 3'b101);
        push(8, 3'd1);  ticks(8);
        push(24, 3'd0); ticks(24);

        // Write entry1 in its own LOAD cycle: old value (incl. dwell 2) is shown
        push(8, 3'd1);
        ticks(7);
        @(negedge clk);
        pos_tick = 1'b1;
        tick_cnt++;
        @(negedge clk);
        pos_tick = 1'b0;
        wr_en = 1'b1; wr_addr = 3'd1; wr_data = ent(4'd0, 1'b1, 1'b0, 1'b0, 3'b011);
        pl[1] = wr_data;
        @(negedge clk);
        wr_en = 1'b0;
        @(negedge clk);
        push(24, 3'd0); ticks(24);
        push(8, 3'd1);  ticks(8);

        // last_addr lowered below current index wraps to 0, then stays at 0
        last_addr = 3'd0;
        push(8, 3'd0); ticks(8);
        push(8, 3'd0); ticks(8);
`endif

        // Reset mid-RUN clears everything, including the playlist
        ticks(3);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk_reset_state("midrst");
        reset = 1'b0;
        for (int i = 0; i < 8; i++) pl[i] = '0;
        repeat (3) @(negedge clk);
        chk("post_rst_busy", busy, 1);
        chk("post_rst_speed", cfg_speed, 0);
        chk("post_rst_tail", cfg_tail, 0);
        run = 1'b0;
        repeat (3) @(negedge clk);
        chk("sb_drained", sbq.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
